// File: rtl/tlb_cache.sv
// ============================================================================
// Module   : tlb_cache
// Brief    : Set-associative TLB with one-cycle lookup, refill port, PCID flush.
//            Optional macro TLB_GLOBAL_PAGE_EN adds PCID-agnostic global pages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_cache #(
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 8,
  parameter int PCID_W     = 12,
  parameter int PAGE_SHIFT = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [63:0]         in_addr,
  input  logic [PCID_W-1:0]   in_pcid,
  output logic [63:0]         o_addr,
  output logic [NUM_WAYS-1:0] hit,
  input  logic                fill_en,
  input  logic [63:0]         fill_vaddr,
  input  logic [PCID_W-1:0]   fill_pcid,
  input  logic [63:0]         fill_paddr,
`ifdef TLB_GLOBAL_PAGE_EN
  input  logic                fill_global,
`endif
  input  logic                flush_en,
  input  logic [PCID_W-1:0]   flush_pcid
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int VPN_W = 64 - PAGE_SHIFT;
  localparam int TAG_W = VPN_W - SET_W;

  logic [NUM_WAYS-1:0] r_valid  [NUM_SETS];
  logic [WAY_W-1:0]    r_victim [NUM_SETS];
  logic [TAG_W-1:0]    r_tag    [NUM_SETS][NUM_WAYS];
  logic [PCID_W-1:0]   r_pcid   [NUM_SETS][NUM_WAYS];
  logic [VPN_W-1:0]    r_ppn    [NUM_SETS][NUM_WAYS];
`ifdef TLB_GLOBAL_PAGE_EN
  logic [NUM_WAYS-1:0] r_global [NUM_SETS];
`endif

  logic [SET_W-1:0]    w_lk_set, w_fl_set;
  logic [TAG_W-1:0]    w_lk_tag, w_fl_tag;
  logic [NUM_WAYS-1:0] w_lk_match, w_fl_valid, w_fl_match, w_hit_oh;
  logic [NUM_WAYS-1:0] w_flush_kill [NUM_SETS];
  logic [VPN_W-1:0]    w_hit_ppn;
  logic                w_hit_any;
  logic [WAY_W-1:0]    w_fill_way, w_victim_next;
  logic                w_fill_evict;
  logic                w_unused_ok;

  assign w_lk_set = in_addr[PAGE_SHIFT +: SET_W];
  assign w_lk_tag = in_addr[63 -: TAG_W];
  assign w_fl_set = fill_vaddr[PAGE_SHIFT +: SET_W];
  assign w_fl_tag = fill_vaddr[63 -: TAG_W];
  assign w_unused_ok = ^{fill_vaddr[PAGE_SHIFT-1:0], fill_paddr[PAGE_SHIFT-1:0]};

  // Flush kill mask over the whole array; global pages are immune.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        w_flush_kill[s][w] = flush_en && (r_pcid[s][w] == flush_pcid)
`ifdef TLB_GLOBAL_PAGE_EN
                             && !r_global[s][w]
`endif
                             ;
      end
    end
  end

  // Lookup and fill-side matching; the fill side sees post-flush validity.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_lk_match[w] = r_valid[w_lk_set][w] && (r_tag[w_lk_set][w] == w_lk_tag) &&
                      ((r_pcid[w_lk_set][w] == in_pcid)
`ifdef TLB_GLOBAL_PAGE_EN
                       || r_global[w_lk_set][w]
`endif
                      );
      w_fl_valid[w] = r_valid[w_fl_set][w] && !w_flush_kill[w_fl_set][w];
      w_fl_match[w] = w_fl_valid[w] && (r_tag[w_fl_set][w] == w_fl_tag) &&
                      ((r_pcid[w_fl_set][w] == fill_pcid)
`ifdef TLB_GLOBAL_PAGE_EN
                       || r_global[w_fl_set][w]
`endif
                      );
    end
  end

  // Lowest matching way wins, keeping the hit vector one-hot.
  always_comb begin
    w_hit_oh  = '0;
    w_hit_ppn = '0;
    w_hit_any = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_lk_match[w]) begin
        w_hit_oh    = '0;
        w_hit_oh[w] = 1'b1;
        w_hit_ppn   = r_ppn[w_lk_set][w];
        w_hit_any   = 1'b1;
      end
    end
  end

  // Way choice: existing match, else lowest free way, else round-robin victim.
  always_comb begin
    w_fill_way   = r_victim[w_fl_set];
    w_fill_evict = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!w_fl_valid[w]) begin
        w_fill_way   = WAY_W'(w);
        w_fill_evict = 1'b0;
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_fl_match[w]) begin
        w_fill_way   = WAY_W'(w);
        w_fill_evict = 1'b0;
      end
    end
  end

  assign w_victim_next = (r_victim[w_fl_set] == WAY_W'(NUM_WAYS - 1)) ? '0
                       : r_victim[w_fl_set] + WAY_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s]  <= '0;
        r_victim[s] <= '0;
      end
      hit    <= '0;
      o_addr <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= r_valid[s] & ~w_flush_kill[s];
      end
      if (fill_en) begin
        r_valid[w_fl_set][w_fill_way] <= 1'b1;
        if (w_fill_evict) r_victim[w_fl_set] <= w_victim_next;
      end
      hit    <= w_hit_oh;
      o_addr <= w_hit_any ? {w_hit_ppn, in_addr[PAGE_SHIFT-1:0]} : 64'd0;
    end
  end

  // Payload arrays carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      r_tag[w_fl_set][w_fill_way]  <= w_fl_tag;
      r_pcid[w_fl_set][w_fill_way] <= fill_pcid;
      r_ppn[w_fl_set][w_fill_way]  <= fill_paddr[63:PAGE_SHIFT];
`ifdef TLB_GLOBAL_PAGE_EN
      r_global[w_fl_set][w_fill_way] <= fill_global;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlb_cache.sv
// ============================================================================
// Module   : tb_tlb_cache
// Brief    : Randomized self-checking bench for tlb_cache against a table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_cache;

  localparam int NS = 4;
  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_addr = '0;
  logic [11:0] in_pcid = '0;
  logic [63:0] o_addr;
  logic [7:0]  hit;
  logic        fill_en = 1'b0;
  logic [63:0] fill_vaddr = '0;
  logic [11:0] fill_pcid = '0;
  logic [63:0] fill_paddr = '0;
  logic        flush_en = 1'b0;
  logic [11:0] flush_pcid = '0;
`ifdef TLB_GLOBAL_PAGE_EN
  logic        fill_global = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tlb_cache dut (
    .clk(clk), .rst_n(rst_n), .in_addr(in_addr), .in_pcid(in_pcid),
    .o_addr(o_addr), .hit(hit), .fill_en(fill_en), .fill_vaddr(fill_vaddr),
    .fill_pcid(fill_pcid), .fill_paddr(fill_paddr),
`ifdef TLB_GLOBAL_PAGE_EN
    .fill_global(fill_global),
`endif
    .flush_en(flush_en), .flush_pcid(flush_pcid)
  );

  // Reference model: a table of (vpn, pcid, ppn) entries per set.
  bit          m_valid  [NS][NW];
  logic [51:0] m_vpn    [NS][NW];
  logic [11:0] m_pcid   [NS][NW];
  logic [51:0] m_ppn    [NS][NW];
  int          m_victim [NS];

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_victim[s] = 0;
      for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
    end
  endfunction

  function automatic void model_lookup(input logic [63:0] a, input logic [11:0] p,
                                       output logic [7:0] eh, output logic [63:0] ea);
    int s = int'(a[63:12] % NS);
    bit found = 0;
    eh = '0;
    ea = '0;
    for (int w = 0; w < NW; w++) begin
      if (!found && m_valid[s][w] && m_vpn[s][w] == a[63:12] && m_pcid[s][w] == p) begin
        found = 1;
        eh = 8'(1) << w;
        ea = {m_ppn[s][w], a[11:0]};
      end
    end
  endfunction

  function automatic void model_flush(input logic [11:0] p);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (m_pcid[s][w] == p) m_valid[s][w] = 0;
  endfunction

  function automatic void model_fill(input logic [63:0] va, input logic [11:0] p,
                                     input logic [63:0] pa);
    int s = int'(va[63:12] % NS);
    int idx = -1;
    for (int w = 0; w < NW; w++)
      if (idx < 0 && m_valid[s][w] && m_vpn[s][w] == va[63:12] && m_pcid[s][w] == p) idx = w;
    for (int w = 0; w < NW; w++)
      if (idx < 0 && !m_valid[s][w]) idx = w;
    if (idx < 0) begin
      idx = m_victim[s];
      m_victim[s] = (m_victim[s] + 1) % NW;
    end
    m_valid[s][idx] = 1;
    m_vpn[s][idx]   = va[63:12];
    m_pcid[s][idx]  = p;
    m_ppn[s][idx]   = pa[63:12];
  endfunction

  // One clock: predict from pre-edge state, advance, then apply flush and fill.
  task automatic tick(output logic [7:0] eh, output logic [63:0] ea);
    model_lookup(in_addr, in_pcid, eh, ea);
    @(posedge clk);
    #1;
    if (flush_en) model_flush(flush_pcid);
    if (fill_en) model_fill(fill_vaddr, fill_pcid, fill_paddr);
  endtask

  task automatic do_fill(input logic [51:0] vpn, input logic [11:0] p, input logic [51:0] ppn);
    logic [7:0]  eh;
    logic [63:0] ea;
    fill_en    = 1'b1;
    fill_vaddr = {vpn, 12'($urandom)};
    fill_pcid  = p;
    fill_paddr = {ppn, 12'($urandom)};
    tick(eh, ea);
    fill_en = 1'b0;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0]  eh;
    logic [63:0] ea;
    rst_n = 1'b0;
    #7;
    checks++;
    if (hit !== 8'h00 || o_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: hit=%h o_addr=%h, want 00 / 0", hit, o_addr);
    end
    rst_n = 1'b1;
    model_reset();
    in_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    in_pcid = 12'd0;
    repeat (3) begin
      tick(eh, ea);
      checks++;
      if (hit !== 8'h00 || o_addr !== 64'd0) begin
        errors++;
        $display("FAIL empty_lookup: hit=%h o_addr=%h, want 00 / 0", hit, o_addr);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0]  eh;
    logic [63:0] ea;
    do_fill(52'h403, 12'd5, 52'h80000);
    in_addr = 64'h403ABC;
    in_pcid = 12'd5;
    tick(eh, ea);
    checks++;
    if (hit !== 8'h01 || o_addr !== 64'h8000_0ABC) begin
      errors++;
      $display("FAIL basic_hit: hit=%h o_addr=%h, want 01 / 80000abc", hit, o_addr);
    end
    in_pcid = 12'd6;
    tick(eh, ea);
    checks++;
    if (hit !== 8'h00 || o_addr !== 64'd0) begin
      errors++;
      $display("FAIL pcid_miss: hit=%h o_addr=%h, want 00 / 0", hit, o_addr);
    end
  endtask

  task automatic test_eviction();
    logic [7:0]  eh, want;
    logic [63:0] ea;
    for (int k = 0; k < 9; k++) do_fill(52'((k + 1) * 4), 12'd7, 52'(32'h100 + k));
    in_pcid = 12'd7;
    for (int k = 0; k < 9; k++) begin
      in_addr = {52'((k + 1) * 4), 12'h123};
      tick(eh, ea);
      want = (k == 0) ? 8'h00 : (k == 8) ? 8'h01 : 8'(1) << k;
      checks++;
      if (hit !== want || (want != 0 && o_addr !== {52'(32'h100 + k), 12'h123})
          || (want == 0 && o_addr !== 64'd0)) begin
        errors++;
        $display("FAIL evict_vpn%0d: hit=%h o_addr=%h, want hit=%h", k, hit, o_addr, want);
      end
    end
  endtask

  task automatic test_refill();
    logic [7:0]  eh;
    logic [63:0] ea;
    do_fill(52'd16, 12'd7, 52'hABC);
    in_addr = {52'd16, 12'h055};
    in_pcid = 12'd7;
    tick(eh, ea);
    checks++;
    if (hit !== 8'h08 || o_addr !== 64'hABC055) begin
      errors++;
      $display("FAIL refill_inplace: hit=%h o_addr=%h, want 08 / abc055", hit, o_addr);
    end
    // Pointer must still be at way 1 after the in-place refill.
    do_fill(52'd40, 12'd7, 52'h777);
    in_addr = {52'd40, 12'h001};
    tick(eh, ea);
    checks++;
    if (hit !== 8'h02 || o_addr !== 64'h777001) begin
      errors++;
      $display("FAIL refill_victim: hit=%h o_addr=%h, want 02 / 777001", hit, o_addr);
    end
    in_addr = {52'd8, 12'h001};
    tick(eh, ea);
    checks++;
    if (hit !== 8'h00) begin
      errors++;
      $display("FAIL victim_evicted: hit=%h, want 00", hit);
    end
  endtask

  task automatic test_flush();
    logic [7:0]  eh;
    logic [63:0] ea;
    logic [51:0] vpns [4] = '{52'h2, 52'h6, 52'hA, 52'hE};
    logic [11:0] pcs  [4] = '{12'd3, 12'd4, 12'd3, 12'd3};
    logic [7:0]  want [4] = '{8'h00, 8'h02, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) do_fill(vpns[i], pcs[i], 52'h500 + 52'(i));
    // Flush and fill together; the same-cycle lookup still sees way 0.
    in_addr    = {52'h2, 12'h0};
    in_pcid    = 12'd3;
    flush_en   = 1'b1;
    flush_pcid = 12'd3;
    fill_en    = 1'b1;
    fill_vaddr = {52'hE, 12'h0};
    fill_pcid  = 12'd3;
    fill_paddr = {52'h503, 12'h0};
    tick(eh, ea);
    flush_en = 1'b0;
    fill_en  = 1'b0;
    checks++;
    if (hit !== 8'h01 || o_addr !== 64'h500000) begin
      errors++;
      $display("FAIL flush_preedge: hit=%h o_addr=%h, want 01 / 500000", hit, o_addr);
    end
    for (int i = 0; i < 4; i++) begin
      in_addr = {vpns[i], 12'h0};
      in_pcid = pcs[i];
      tick(eh, ea);
      checks++;
      if (hit !== want[i] || hit !== eh || o_addr !== ea) begin
        errors++;
        $display("FAIL flush_vpn%0d: hit=%h o_addr=%h, want hit=%h o_addr=%h",
                 i, hit, o_addr, want[i], ea);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  eh;
    logic [63:0] ea;
    for (int n = 0; n < 400; n++) begin
      in_addr    = {52'($urandom_range(0, 15)), 12'($urandom)};
      in_pcid    = 12'($urandom_range(0, 2));
      fill_en    = ($urandom_range(0, 9) < 3);
      fill_vaddr = {52'($urandom_range(0, 15)), 12'($urandom)};
      fill_pcid  = 12'($urandom_range(0, 2));
      fill_paddr = {32'($urandom), 32'($urandom)};
      flush_en   = ($urandom_range(0, 19) == 0);
      flush_pcid = 12'($urandom_range(0, 2));
      tick(eh, ea);
      checks++;
      if (hit !== eh || o_addr !== ea) begin
        errors++;
        $display("FAIL random_%0d: hit=%h o_addr=%h, want hit=%h o_addr=%h",
                 n, hit, o_addr, eh, ea);
      end
    end
    fill_en  = 1'b0;
    flush_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0]  eh;
    logic [63:0] ea;
    sync_reset();
    do_fill(52'd1, 12'd1, 52'h11);
    do_fill(52'd5, 12'd1, 52'h55);
    do_fill(52'd9, 12'd1, 52'h99);
    in_addr = {52'd9, 12'h0};
    in_pcid = 12'd1;
    tick(eh, ea);
    checks++;
    if (hit !== 8'h04 || o_addr !== 64'h99000) begin
      errors++;
      $display("FAIL pre_async: hit=%h o_addr=%h, want 04 / 99000", hit, o_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hit !== 8'h00 || o_addr !== 64'd0) begin
      errors++;
      $display("FAIL async_clear: hit=%h o_addr=%h, want 00 / 0", hit, o_addr);
    end
    #10;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      in_addr = {52'(1 + 4 * k), 12'h0};
      tick(eh, ea);
      checks++;
      if (hit !== 8'h00 || o_addr !== 64'd0) begin
        errors++;
        $display("FAIL post_reset_vpn%0d: hit=%h o_addr=%h, want 00 / 0", k, hit, o_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eviction();
    test_refill();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
